control_step_sequencer: RTL

Parametrised timing-step generator for the Mini SRC control unit. It sequences every instruction through one-hot T-steps, from a fixed fetch prefix to an opcode-dependent execute length. It stalls on memory wait, halts cleanly at an instruction boundary on `stop`, and resumes on `start`. Its `t_step` outputs feed the control decoder, which turns (opcode, step) into the datapath's register/bus enable signals.

---
 rtl/control_step_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/control_step_sequencer.sv
// Timing-step generator for the Mini SRC control unit: walks every instruction through
// one-hot T-steps, a fixed fetch prefix followed by a decoder-supplied execute length.
module control_step_sequencer #(
  parameter int STEPS       = 8,
  parameter int FETCH_STEPS = 3,
  parameter int SW          = $clog2(STEPS),
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic [SW:0]      op_len,
  input  logic             mem_wait,
  output logic             run,
  output logic [STEPS-1:0] t_step,
  output logic [SW-1:0]    step_idx,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALTED
  } state_t;

  localparam logic [SW:0]   LEN_MIN    = (SW + 1)'(FETCH_STEPS + 1);
  localparam logic [SW:0]   LEN_MAX    = (SW + 1)'(STEPS);
  localparam logic [SW-1:0] FETCH_LAST = SW'(FETCH_STEPS - 1);

  state_t           state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [SW:0]      len_q, len_d;
  logic             stop_pending_q, stop_pending_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             running;
  logic             at_last;

  assign running = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign at_last = (state_q == S_EXEC) && ({1'b0, step_q} == (len_q - 1'b1));

  always_comb begin
    state_d        = state_q;
    step_d         = step_q;
    len_d          = len_q;
    stop_pending_d = stop_pending_q;
    instr_count_d  = instr_count_q;
    stall_count_d  = stall_count_q;

    if (running && stop) begin
      stop_pending_d = 1'b1;
    end
    if (running && mem_wait && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start && !stop) begin
          state_d = S_FETCH;
          step_d  = '0;
        end
      end
      S_FETCH: begin
        if (!mem_wait) begin
          step_d = step_q + 1'b1;
          if (step_q == FETCH_LAST) begin
            // The decoder's length is only trusted here; clamp so EXEC always has a step.
            state_d = S_EXEC;
            if (op_len < LEN_MIN) begin
              len_d = LEN_MIN;
            end else if (op_len > LEN_MAX) begin
              len_d = LEN_MAX;
            end else begin
              len_d = op_len;
            end
          end
        end
      end
      S_EXEC: begin
        if (!mem_wait) begin
          if (at_last) begin
            instr_count_d = instr_count_q + 1'b1;
            step_d        = '0;
            if (stop_pending_q || stop) begin
              state_d        = S_HALTED;
              stop_pending_d = 1'b0;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q        <= S_IDLE;
      step_q         <= '0;
      len_q          <= LEN_MIN;
      stop_pending_q <= 1'b0;
      instr_count_q  <= '0;
      stall_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      len_q          <= len_d;
      stop_pending_q <= stop_pending_d;
      instr_count_q  <= instr_count_d;
      stall_count_q  <= stall_count_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STEPS; gi++) begin : g_onehot
      assign t_step[gi] = running && (step_q == SW'(gi));
    end
  endgenerate

  // A frozen last step must not report completion, so the pulse is qualified by the live wait.
  assign instr_done  = at_last && !mem_wait;
  assign run         = running;
  assign step_idx    = step_q;
  assign instr_count = instr_count_q;
  assign stall_count = stall_count_q;

endmodule
